rgmii_tx: RTL and testbench
===========================

// Module: rgmii_tx
// PURPOSE
// - Ethernet transmit framer plus RGMII output stage; transmit-side counterpart of the RGMII receiver.
// - Takes a byte stream (valid/ready/last) of one frame (DA..payload, no preamble/FCS).
// - Adds preamble, SFD, min-length padding, FCS and inter-packet gap.
// - Drives RGMII TXC/TX_CTL/TXD[3:0] through PH1_LOGIC_ODDR primitives.
// PARAMETERS
// - MIN_FRAME     60  min bytes before FCS; shorter frames are zero-padded
// - IPG_BYTES     12  idle byte-times after last FCS byte before next preamble
// - PREAMBLE_LEN  7   0x55 bytes before SFD (0xD5)
// PORTS
// - gmii_tx_clk   in   1  125 MHz byte clock; the only clock
// - rst_n         in   1  reset, synchronous, active-low
// - s_data        in   8  frame byte
// - s_valid       in   1  s_data valid
// - s_last        in   1  s_data is last byte of frame
// - s_ready       out  1  byte accepted when s_valid & s_ready
// - rgmii_txc     out  1  RGMII TX clock (ODDR d0=1, d1=0)
// - rgmii_tx_ctl  out  1  rising edge: tx_en; falling edge: tx_en ^ tx_er
// - rgmii_txd     out  4  rising edge: byte[3:0]; falling edge: byte[7:4]
// - tx_busy       out  1  high in every state except IDLE
// - tx_done       out  1  1-cycle pulse on the last IPG cycle
// - tx_underrun   out  1  1-cycle pulse when an underrun is detected
// BEHAVIOUR
// - Internal registered GMII byte: txd_r[7:0], tx_en_r, tx_er_r feed the ODDRs; pin delay is 1 cycle after the register.
// - Reset: on rst_n low at a clock edge, FSM goes to IDLE.
//   - txd_r, tx_en_r, tx_er_r, s_ready, tx_busy, tx_done, tx_underrun, CRC and counters are all cleared.
//   - Reset mid-frame truncates the frame; no FCS is sent.
// - FSM: IDLE -> PRE -> SFD -> DATA -> [PAD] -> FCS -> IPG -> IDLE.
//   - IDLE: tx_en_r=0. If s_valid=1, the next cycle enters PRE. s_data is not consumed.
//   - PRE: PREAMBLE_LEN cycles of 0x55, tx_en_r=1.
//   - SFD: 1 cycle of 0xD5.
//   - DATA: s_ready=1 combinationally in this state only; one byte per cycle.
//     - txd_r <= s_data; byte_cnt++ (saturating at 16 bits).
//     - Byte with s_last: go to PAD if byte_cnt+1 < MIN_FRAME, else to FCS.
//   - PAD: send 0x00 until byte_cnt == MIN_FRAME.
//   - FCS: 4 cycles; fields defined under CONFIGURATION.
//   - IPG: IPG_BYTES cycles with tx_en_r=0; tx_done pulses on the final cycle; s_valid is ignored.
// - Underrun: s_valid=0 in DATA.
//   - That cycle: tx_er_r=1, tx_en_r=1, txd_r=0x00; tx_underrun pulses.
//   - Then jump to IPG with no PAD and no FCS.
//   - Upstream must drop the rest of the frame; the block does not flush it.
// - s_last on the first DATA byte is legal (1-byte frame, padded to MIN_FRAME).
// - Back-to-back frames: gap is exactly IPG_BYTES cycles of tx_en=0 between the last FCS byte and the first 0x55.
// - Frame length on the wire (tx_en=1 cycles) = PREAMBLE_LEN + 1 + max(N, MIN_FRAME) + 4.
// CONFIGURATION
// - Macro RGMII_TX_FCS_EN.
// - Defined: CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF).
//   - Computed over DATA and PAD bytes, updated in the same cycle each byte is loaded.
//   - FCS state sends ~crc, LSB byte first.
// - Undefined: no CRC logic; the FCS state is removed (DATA/PAD go straight to IPG).
//   - Upstream supplies the FCS inside the stream; padding still applies to MIN_FRAME.
// TESTING
// - Reset check: rst_n=0 for 3 cycles, with s_valid=1 -> tx_en=0, s_ready=0, tx_busy=0 throughout; IDLE after release.
// - 64-byte frame, 0x00..0x3F, FCS_EN -> 7x0x55, 0xD5, 64 bytes, 4 FCS bytes matching reference CRC.
//   - tx_en high for 76 cycles; tx_done 12 cycles after the last FCS byte.
// - 14-byte frame -> 46 bytes 0x00 padded; FCS covers 60 bytes; tx_en high for 72 cycles.
// - Underrun: s_valid drops after byte 20 -> one cycle with tx_en=1 and tx_er=1.
//   - On pins: falling-edge ctl=0; tx_underrun pulses; no FCS; IPG follows.
// - Two frames back-to-back with s_valid held high -> exactly 12 cycles of tx_en=0 between frames; s_ready=0 during IPG.
// - DDR pin check: byte 0xA5 -> txd=0x5 on rising edge, 0xA on falling edge; txc toggles each half-cycle.

Source files
------------

// File: rtl/rgmii_tx.sv
// -----------------------------------------------------------------------------
// rgmii_tx
//   Ethernet transmit framer with RGMII output stage. Accepts one frame as a
//   byte stream (destination address through payload, no preamble, no FCS),
//   then puts on the wire: preamble, SFD, the frame bytes, zero padding up to
//   MIN_FRAME, optional FCS, and an inter-packet gap.
//
//   Optional feature macro: RGMII_TX_FCS_EN
//     defined   : CRC-32 is computed over DATA+PAD bytes and sent as the FCS.
//     undefined : no CRC logic and no FCS state; the upstream source must
//                 embed the FCS in its stream (padding still applies).
//
// Ports
//   gmii_tx_clk   in   125 MHz byte clock (only clock)
//   rst_n         in   synchronous active-low reset
//   s_data[7:0]   in   frame byte
//   s_valid       in   s_data valid
//   s_last        in   s_data is the final byte of the frame
//   s_ready       out  byte accepted when s_valid & s_ready (DATA state only)
//   rgmii_txc     out  RGMII transmit clock
//   rgmii_tx_ctl  out  rising half: tx_en, falling half: tx_en ^ tx_er
//   rgmii_txd[3:0]out  rising half: byte[3:0], falling half: byte[7:4]
//   tx_busy       out  high whenever the framer is not idle
//   tx_done       out  one-cycle pulse on the last inter-packet-gap cycle
//   tx_underrun   out  one-cycle pulse when the source starves mid-frame
// -----------------------------------------------------------------------------
module rgmii_tx #(
  parameter int MIN_FRAME    = 60,
  parameter int IPG_BYTES    = 12,
  parameter int PREAMBLE_LEN = 7
) (
  input  logic       gmii_tx_clk,
  input  logic       rst_n,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic       rgmii_txc,
  output logic       rgmii_tx_ctl,
  output logic [3:0] rgmii_txd,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_underrun
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRE  = 3'd1;
  localparam logic [2:0] ST_SFD  = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_PAD  = 3'd4;
  localparam logic [2:0] ST_IPG  = 3'd6;
`ifdef RGMII_TX_FCS_EN
  localparam logic [2:0] ST_FCS  = 3'd5;
  // State entered once payload and padding are complete.
  localparam logic [2:0] ST_TAIL = ST_FCS;
`else
  localparam logic [2:0] ST_TAIL = ST_IPG;
`endif

  logic [2:0]  r_state;
  logic [7:0]  r_cnt;        // shared by PRE, FCS and IPG; zero on entry to each
  logic [15:0] r_byte_cnt;   // DATA + PAD bytes sent in this frame
  logic [7:0]  r_txd;
  logic        r_tx_en;
  logic        r_tx_er;
  logic        r_tx_done;
  logic        r_tx_underrun;
  logic [15:0] w_byte_cnt_inc;
  logic        w_short;

  // Saturating increment so a very long frame cannot wrap and re-trigger padding.
  assign w_byte_cnt_inc = (&r_byte_cnt) ? r_byte_cnt : r_byte_cnt + 16'd1;
  assign w_short        = (w_byte_cnt_inc < 16'(MIN_FRAME));

`ifdef RGMII_TX_FCS_EN
  logic [31:0] r_crc;
  logic [31:0] w_crc_inv;

  // Reflected CRC-32 (poly 0x04C11DB7 -> 0xEDB88320), one byte, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ d[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  assign w_crc_inv = ~r_crc;
`endif

  always_ff @(posedge gmii_tx_clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_byte_cnt    <= '0;
      r_txd         <= '0;
      r_tx_en       <= 1'b0;
      r_tx_er       <= 1'b0;
      r_tx_done     <= 1'b0;
      r_tx_underrun <= 1'b0;
`ifdef RGMII_TX_FCS_EN
      r_crc         <= 32'hFFFFFFFF;
`endif
    end else begin
      r_tx_er       <= 1'b0;
      r_tx_done     <= 1'b0;
      r_tx_underrun <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_tx_en <= 1'b0;
          r_txd   <= 8'h00;
          r_cnt   <= '0;
          if (s_valid) r_state <= ST_PRE;
        end
        ST_PRE: begin
          r_tx_en    <= 1'b1;
          r_txd      <= 8'h55;
          r_byte_cnt <= '0;
`ifdef RGMII_TX_FCS_EN
          r_crc      <= 32'hFFFFFFFF;
`endif
          if (r_cnt == 8'(PREAMBLE_LEN - 1)) begin
            r_cnt   <= '0;
            r_state <= ST_SFD;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_SFD: begin
          r_tx_en <= 1'b1;
          r_txd   <= 8'hD5;
          r_state <= ST_DATA;
        end
        ST_DATA: begin
          r_tx_en <= 1'b1;
          if (s_valid) begin
            r_txd      <= s_data;
            r_byte_cnt <= w_byte_cnt_inc;
`ifdef RGMII_TX_FCS_EN
            r_crc      <= crc_byte(r_crc, s_data);
`endif
            if (s_last) r_state <= w_short ? ST_PAD : ST_TAIL;
          end else begin
            // Source starved: mark the byte as an error and abandon the frame.
            r_txd         <= 8'h00;
            r_tx_er       <= 1'b1;
            r_tx_underrun <= 1'b1;
            r_cnt         <= '0;
            r_state       <= ST_IPG;
          end
        end
        ST_PAD: begin
          r_tx_en    <= 1'b1;
          r_txd      <= 8'h00;
          r_byte_cnt <= w_byte_cnt_inc;
`ifdef RGMII_TX_FCS_EN
          r_crc      <= crc_byte(r_crc, 8'h00);
`endif
          if (!w_short) r_state <= ST_TAIL;
        end
`ifdef RGMII_TX_FCS_EN
        ST_FCS: begin
          r_tx_en <= 1'b1;
          r_txd   <= w_crc_inv[{r_cnt[1:0], 3'b000} +: 8];
          if (r_cnt == 8'd3) begin
            r_cnt   <= '0;
            r_state <= ST_IPG;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
`endif
        ST_IPG: begin
          r_tx_en <= 1'b0;
          r_txd   <= 8'h00;
          if (r_cnt == 8'(IPG_BYTES - 1)) begin
            r_cnt     <= '0;
            r_tx_done <= 1'b1;
            // Going straight to PRE keeps back-to-back gaps at exactly IPG_BYTES.
            r_state   <= s_valid ? ST_PRE : ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_ready     = (r_state == ST_DATA);
  assign tx_busy     = (r_state != ST_IDLE);
  assign tx_done     = r_tx_done;
  assign tx_underrun = r_tx_underrun;

  // ---------------------------------------------------------------------------
  // Output DDR stage: behavioural equivalent of PH1_LOGIC_ODDR. Each lane
  // captures (d0, d1) on the rising edge, drives d0 while the clock is high and
  // d1 while it is low, giving one cycle of latency after the GMII register.
  // Lane order: [5]=txc, [4]=tx_ctl, [3:0]=txd.
  // ---------------------------------------------------------------------------
  logic [5:0] w_d0;
  logic [5:0] w_d1;
  logic [5:0] r_pin_d0;
  logic [5:0] r_pin_d1;
  logic [5:0] w_pin;

  assign w_d0 = {1'b1, r_tx_en,           r_txd[3:0]};
  assign w_d1 = {1'b0, r_tx_en ^ r_tx_er, r_txd[7:4]};

  always_ff @(posedge gmii_tx_clk) begin
    if (!rst_n) begin
      r_pin_d0 <= '0;
      r_pin_d1 <= '0;
    end else begin
      r_pin_d0 <= w_d0;
      r_pin_d1 <= w_d1;
    end
  end

  for (genvar gi = 0; gi < 6; gi++) begin : g_oddr
    assign w_pin[gi] = gmii_tx_clk ? r_pin_d0[gi] : r_pin_d1[gi];
  end

  assign rgmii_txc    = w_pin[5];
  assign rgmii_tx_ctl = w_pin[4];
  assign rgmii_txd    = w_pin[3:0];

endmodule

// File: tb/tb_rgmii_tx.sv
// -----------------------------------------------------------------------------
// tb_rgmii_tx
//   Drives frames (directed and $urandom) into rgmii_tx, builds the expected
//   wire byte sequence per frame from the framing rules (preamble, SFD, data,
//   zero pad to 60, optional FCS, underrun error byte), and a monitor decodes
//   the DDR pins every cycle and compares against that queue.
// -----------------------------------------------------------------------------
module tb_rgmii_tx;

  localparam int MIN_FRAME = 60;
  localparam int IPG_BYTES = 12;
  localparam int PRE_LEN   = 7;
`ifdef RGMII_TX_FCS_EN
  localparam int FCS_BYTES = 4;
`else
  localparam int FCS_BYTES = 0;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;
  logic       rgmii_txc;
  logic       rgmii_tx_ctl;
  logic [3:0] rgmii_txd;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_underrun;

  rgmii_tx #(.MIN_FRAME(MIN_FRAME), .IPG_BYTES(IPG_BYTES), .PREAMBLE_LEN(PRE_LEN)) dut (
    .gmii_tx_clk (clk),
    .rst_n       (rst_n),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .rgmii_txc   (rgmii_txc),
    .rgmii_tx_ctl(rgmii_tx_ctl),
    .rgmii_txd   (rgmii_txd),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_underrun (tx_underrun)
  );

  initial begin
    clk = 1'b0;
    forever #4 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected wire stream: {tx_er, byte} for every tx_en=1 cycle.
  logic [8:0] exp_q[$];
  int         len_q[$];
  bit         gap_q[$];   // 1: gap may be longer than IPG (source paused)
  int         obs_len[$];
  int         frames_sent = 0;
  int         n_und = 0;

  function automatic logic [31:0] fcs_of(input byte unsigned b[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic push_byte(input logic [7:0] d, input bit last);
    bit rdy;
    bit got;
    got     = 1'b0;
    s_data  = d;
    s_valid = 1'b1;
    s_last  = last;
    for (int w = 0; w < 300 && !got; w++) begin
      #1;
      rdy = s_ready;
      @(posedge clk);
      #1;
      got = rdy;
    end
    if (!got) chk("handshake_timeout", 1'b0, 64'(d), 64'(d));
  endtask

  task automatic send_frame(input int n, input int k_und, input int delay, input int kind);
    byte unsigned data[$];
    byte unsigned body[$];
    logic [31:0]  c;
    for (int i = 0; i < n; i++) begin
      if (kind == 0)                data.push_back(8'(i));
      else if (kind == 1 && i == 0) data.push_back(8'hA5);
      else                          data.push_back(8'($urandom_range(0, 255)));
    end
    for (int i = 0; i < PRE_LEN; i++) exp_q.push_back({1'b0, 8'h55});
    exp_q.push_back({1'b0, 8'hD5});
    if (k_und > 0) begin
      for (int i = 0; i < k_und; i++) exp_q.push_back({1'b0, data[i]});
      exp_q.push_back({1'b1, 8'h00});
      len_q.push_back(PRE_LEN + 1 + k_und + 1);
      n_und++;
    end else begin
      body = data;
      while (body.size() < MIN_FRAME) body.push_back(8'h00);
      foreach (body[i]) exp_q.push_back({1'b0, body[i]});
      if (FCS_BYTES == 4) begin
        c = fcs_of(body);
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, c[8*i +: 8]});
      end
      len_q.push_back(PRE_LEN + 1 + body.size() + FCS_BYTES);
    end
    if (frames_sent > 0) gap_q.push_back(delay > 0);
    frames_sent++;

    if (delay > 0) begin
      s_valid = 1'b0;
      s_last  = 1'b0;
      repeat (delay) @(posedge clk);
      #1;
    end
    if (k_und > 0) begin
      for (int i = 0; i < k_und; i++) push_byte(data[i], 1'b0);
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = 8'h00;
      #1;
      chk("ready_at_underrun", s_ready == 1'b1, 64'(s_ready), 64'd1);
      @(posedge clk);
      #1;
    end else begin
      for (int i = 0; i < n; i++) push_byte(data[i], i == n - 1);
    end
    $display("frame %0d: len=%0d underrun_at=%0d delay=%0d", frames_sent - 1, n, k_und, delay);
  endtask

  // ---------------------------------------------------------------- monitor
  bit         mon_en = 1'b0;
  int         run_len = 0;
  int         zero_run = 0;
  int         frames_seen = 0;
  int         done_cnt = 0;
  int         und_cnt = 0;
  bit         prev_und = 1'b0;
  bit         rdy_d1 = 1'b0, rdy_d2 = 1'b0, busy_d1 = 1'b0, busy_d2 = 1'b0;
  logic       m_ctl_r, m_ctl_f, m_txc_h, m_txc_l, m_done, m_und, m_rdy, m_busy;
  logic [3:0] m_lo, m_hi;
  logic [7:0] fr1_first = 8'h00;

  initial begin
    logic       en, er;
    logic [7:0] b;
    logic [8:0] e;
    int         le;
    bit         mode;
    forever begin
      @(posedge clk);
      #2;
      if (mon_en) begin
        m_ctl_r = rgmii_tx_ctl; m_lo = rgmii_txd; m_txc_h = rgmii_txc;
        m_done = tx_done; m_und = tx_underrun; m_rdy = s_ready; m_busy = tx_busy;
        @(negedge clk);
        #2;
        m_ctl_f = rgmii_tx_ctl; m_hi = rgmii_txd; m_txc_l = rgmii_txc;

        chk("txc_phase", {m_txc_h, m_txc_l} == 2'b10, 64'({m_txc_h, m_txc_l}), 64'h2);
        en = m_ctl_r;
        er = m_ctl_r ^ m_ctl_f;
        b  = {m_hi, m_lo};
        if (en) begin
          if (run_len == 0 && frames_seen > 0) begin
            if (gap_q.size() == 0) chk("gap_unexpected_frame", 1'b0, 64'(zero_run), 64'd0);
            else begin
              mode = gap_q.pop_front();
              if (mode) chk("gap_min", zero_run >= IPG_BYTES, 64'(zero_run), 64'(IPG_BYTES));
              else      chk("gap_exact", zero_run == IPG_BYTES, 64'(zero_run), 64'(IPG_BYTES));
            end
          end
          chk("busy_during_frame", busy_d2 == 1'b1, 64'(busy_d2), 64'd1);
          if (exp_q.size() == 0) chk("extra_wire_byte", 1'b0, 64'({er, b}), 64'h0);
          else begin
            e = exp_q.pop_front();
            chk("wire_byte", {er, b} == e, 64'({er, b}), 64'(e));
          end
          if (er) chk("underrun_pulse", prev_und == 1'b1, 64'(prev_und), 64'd1);
          if (frames_seen == 1 && run_len == PRE_LEN + 1) fr1_first = b;
          run_len++;
          zero_run = 0;
        end else begin
          chk("idle_ctl_fall", m_ctl_f == 1'b0, 64'(m_ctl_f), 64'd0);
          chk("ready_low_idle", rdy_d2 == 1'b0, 64'(rdy_d2), 64'd0);
          if (run_len > 0) begin
            if (len_q.size() == 0) chk("frame_len_unexpected", 1'b0, 64'(run_len), 64'd0);
            else begin
              le = len_q.pop_front();
              chk("frame_len", run_len == le, 64'(run_len), 64'(le));
            end
            obs_len.push_back(run_len);
            run_len = 0;
            frames_seen++;
          end
          zero_run++;
        end
        if (m_done) begin
          chk("done_timing", zero_run == IPG_BYTES - 1, 64'(zero_run), 64'(IPG_BYTES - 1));
          done_cnt++;
        end
        if (m_und) und_cnt++;
        prev_und = m_und;
        rdy_d2 = rdy_d1;  rdy_d1 = m_rdy;
        busy_d2 = busy_d1; busy_d1 = m_busy;
      end
    end
  end

  // ---------------------------------------------------------------- main
  initial begin
    byte unsigned ref_str[$];
    int n, k, d, guard;

    // Pin the reference CRC with the standard check value.
    ref_str = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    chk("crc_check_value", fcs_of(ref_str) == 32'hCBF43926, 64'(fcs_of(ref_str)), 64'hCBF43926);

    rst_n = 1'b0; s_valid = 1'b1; s_last = 1'b0; s_data = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_busy", tx_busy == 1'b0, 64'(tx_busy), 64'd0);
      chk("rst_ready", s_ready == 1'b0, 64'(s_ready), 64'd0);
      chk("rst_ctl_rise", rgmii_tx_ctl == 1'b0, 64'(rgmii_tx_ctl), 64'd0);
      @(negedge clk);
      #1;
      chk("rst_ctl_fall", rgmii_tx_ctl == 1'b0, 64'(rgmii_tx_ctl), 64'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1; s_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_busy", tx_busy == 1'b0, 64'(tx_busy), 64'd0);
    chk("idle_ready", s_ready == 1'b0, 64'(s_ready), 64'd0);
    mon_en = 1'b1;

    send_frame(64, 0, 0, 0);   // 0x00..0x3F
    send_frame(14, 0, 0, 1);   // first byte 0xA5, padded
    send_frame(40, 20, 0, 2);  // underrun after 20 bytes
    send_frame(1, 0, 0, 2);
    send_frame(60, 0, 0, 2);
    send_frame(59, 0, 0, 2);
    send_frame(61, 0, 0, 2);
    for (int f = 0; f < 14; f++) begin
      n = $urandom_range(1, 100);
      k = (n >= 2 && $urandom_range(0, 5) == 0) ? int'($urandom_range(1, n - 1)) : 0;
      d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : 0;
      send_frame(n, k, d, 2);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;

    guard = 0;
    while (frames_seen < frames_sent && guard < 3000) begin
      @(posedge clk);
      guard++;
    end
    chk("all_frames_seen", frames_seen == frames_sent, 64'(frames_seen), 64'(frames_sent));
    repeat (20) @(posedge clk);
    #3;

    chk("exp_queue_drained", exp_q.size() == 0, 64'(exp_q.size()), 64'd0);
    chk("done_count", done_cnt == frames_sent, 64'(done_cnt), 64'(frames_sent));
    chk("underrun_count", und_cnt == n_und, 64'(und_cnt), 64'(n_und));
    if (obs_len.size() >= 4) begin
      chk("len_64B", obs_len[0] == 72 + FCS_BYTES, 64'(obs_len[0]), 64'(72 + FCS_BYTES));
      chk("len_14B", obs_len[1] == 68 + FCS_BYTES, 64'(obs_len[1]), 64'(68 + FCS_BYTES));
      chk("len_underrun", obs_len[2] == 29, 64'(obs_len[2]), 64'd29);
      chk("len_1B", obs_len[3] == 68 + FCS_BYTES, 64'(obs_len[3]), 64'(68 + FCS_BYTES));
    end else begin
      chk("frames_observed", 1'b0, 64'(obs_len.size()), 64'd4);
    end
    chk("ddr_rise_nibble", fr1_first[3:0] == 4'h5, 64'(fr1_first[3:0]), 64'h5);
    chk("ddr_fall_nibble", fr1_first[7:4] == 4'hA, 64'(fr1_first[7:4]), 64'hA);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
